// File: rtl/dfe_pkg.sv
// dfe_pkg: shared DFE widths, encodings and fixed-point rounding/saturation helpers
package dfe_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int N_STAGES = 5;
  localparam int MAX_LOG2R = 4;
  function automatic int acc_width(input int dw, input int n, input int m);
    return dw + n * m;
  endfunction
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N_STAGES, MAX_LOG2R);
  localparam int SHIFT_WIDTH = $clog2(N_STAGES * MAX_LOG2R + 1);
  localparam int SAT_WIDTH = ACC_WIDTH + 4;
  typedef logic [2:0] dec_sel_t;
  typedef enum logic [1:0] {GAIN_X1, GAIN_X2, GAIN_X4, GAIN_X8} gain_sel_e;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  ovf;
    logic                  unf;
  } sat_t;
  localparam logic signed [SAT_WIDTH-1:0] SAT_MAX = SAT_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SAT_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;
  function automatic dec_sel_t clamp_dec(input dec_sel_t d);
    return (d > dec_sel_t'(MAX_LOG2R)) ? dec_sel_t'(MAX_LOG2R) : d;
  endfunction
  // arithmetic right shift by s with round-half-up; one guard bit absorbs the rounding carry
  function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] x,
                                                            input logic [SHIFT_WIDTH-1:0] s);
    logic signed [ACC_WIDTH:0] half;
    logic signed [ACC_WIDTH:0] xe;
    half = (s == '0) ? '0 : (ACC_WIDTH + 1)'(1) << (s - SHIFT_WIDTH'(1));
    xe = {x[ACC_WIDTH-1], x};
    xe = xe + half;
    return xe >>> s;
  endfunction
  function automatic sat_t saturate(input logic signed [SAT_WIDTH-1:0] x);
    sat_t r;
    r.ovf = x > SAT_MAX;
    r.unf = x < SAT_MIN;
    r.data = r.ovf ? SAT_MAX[DATA_WIDTH-1:0] : r.unf ? SAT_MIN[DATA_WIDTH-1:0] : x[DATA_WIDTH-1:0];
    return r;
  endfunction
endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: one modular accumulator stage with enable and sync clear
module cic_integrator
  import dfe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [ACC_WIDTH-1:0] in_i,
  output logic [ACC_WIDTH-1:0] sum_o
);
  logic [ACC_WIDTH-1:0] acc_q;
  assign sum_o = acc_q + in_i;
  // accumulate on enable; wrap-around is the intended modular behaviour
  always_ff @(posedge clk)
    if (rst || clr_i) acc_q <= '0;
    else if (en_i) acc_q <= sum_o;
endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: power-of-two CIC decimator with unity DC gain, post-gain, saturation and bypass
module cic_decimator
  import dfe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  bypass,
  input  logic                  cfg_wr_en,
  input  logic [2:0]            dec_sel,
  input  logic [1:0]            gain_sel,
  input  logic [DATA_WIDTH-1:0] cic_in,
  output logic [DATA_WIDTH-1:0] cic_out,
  output logic                  valid_out,
  output logic                  overflow,
  output logic                  underflow,
  output logic [2:0]            dec_sel_out
);
  dec_sel_t                    k_q;
  gain_sel_e                   g_q;
  logic [MAX_LOG2R-1:0]        ph_q, ph_d, ph_last;
  logic [ACC_WIDTH-1:0]        chain [N_STAGES+1];
  logic signed [ACC_WIDTH-1:0] samp_q, comb_q;
  logic signed [ACC_WIDTH-1:0] dly_q [N_STAGES];
  logic signed [ACC_WIDTH-1:0] c [N_STAGES+1];
  logic                        samp_v_q, comb_v_q;
  logic [SHIFT_WIDTH-1:0]      s;
  logic signed [ACC_WIDTH:0]   rs;
  logic signed [SAT_WIDTH-1:0] ext, scaled;
  sat_t                        sat;
  logic [DATA_WIDTH-1:0]       data_q;
  logic                        vout_q, ovf_q, unf_q;
  logic                        accept, last, run1, run2;

  assign accept = valid_in && !bypass && !cfg_wr_en;
  assign ph_last = MAX_LOG2R'((1 << k_q) - 1);
  assign last = ph_q == ph_last;
  assign run1 = samp_v_q && !bypass;
  assign run2 = comb_v_q && !bypass;
  assign chain[0] = {{(ACC_WIDTH - DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};

  for (genvar i = 0; i < N_STAGES; i++) begin : g_int
    cic_integrator u_int (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cfg_wr_en),
      .en_i  (accept),
      .in_i  (chain[i]),
      .sum_o (chain[i+1])
    );
  end

  // phase advance, comb cascade on the decimated stream, and output scaling
  always_comb begin
    ph_d = accept ? (last ? '0 : ph_q + MAX_LOG2R'(1)) : ph_q;
    c[0] = samp_q;
    for (int j = 0; j < N_STAGES; j++) c[j+1] = c[j] - dly_q[j];
    s = SHIFT_WIDTH'(N_STAGES * int'(k_q));
    rs = round_shift(comb_q, s);
    ext = {{(SAT_WIDTH - ACC_WIDTH - 1){rs[ACC_WIDTH]}}, rs};
    scaled = ext <<< g_q;
    sat = saturate(scaled);
  end

  // config, phase, decimated sample latch and comb pipeline; cfg_wr_en flushes everything
  always_ff @(posedge clk)
    if (rst || cfg_wr_en) begin
      k_q <= rst ? '0 : clamp_dec(dec_sel);
      g_q <= rst ? GAIN_X1 : gain_sel_e'(gain_sel);
      ph_q <= '0;
      samp_q <= '0;
      samp_v_q <= 1'b0;
      comb_q <= '0;
      comb_v_q <= 1'b0;
      for (int j = 0; j < N_STAGES; j++) dly_q[j] <= '0;
    end else begin
      ph_q <= ph_d;
      samp_v_q <= accept && last;
      if (accept && last) samp_q <= chain[N_STAGES];
      comb_v_q <= run1;
      if (run1) begin
        comb_q <= c[N_STAGES];
        for (int j = 0; j < N_STAGES; j++) dly_q[j] <= c[j];
      end
    end

  // output register: bypass passthrough or saturated CIC result; holds data across flush
  always_ff @(posedge clk)
    if (rst) begin
      data_q <= '0;
      vout_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (cfg_wr_en) begin
      vout_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bypass) begin
      data_q <= cic_in;
      vout_q <= valid_in;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      vout_q <= run2;
      ovf_q <= run2 && sat.ovf;
      unf_q <= run2 && sat.unf;
      if (run2) data_q <= sat.data;
    end

  assign cic_out = data_q;
  assign valid_out = vout_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  assign dec_sel_out = k_q;
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed vector table plus FIR-model and multi-cycle sequences for cic_decimator
module tb_cic_decimator;
  localparam int NS = 5;
  logic        clk = 1'b0;
  logic        rst, valid_in, bypass, cfg_wr_en;
  logic [2:0]  dec_sel, dec_sel_out;
  logic [1:0]  gain_sel;
  logic [15:0] cic_in, cic_out;
  logic        valid_out, overflow, underflow;
  int          tests = 0, fails = 0, cyc = 0;
  typedef struct { logic [15:0] d; logic o; logic u; int c; } obs_t;
  typedef struct { logic [15:0] x; logic [2:0] ds; logic [1:0] gs; logic [15:0] y; logic o; logic u; logic [2:0] k; } vec_t;
  obs_t obs[$];
  int   xs[$];
  vec_t vt[12];

  cic_decimator dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .bypass(bypass), .cfg_wr_en(cfg_wr_en),
    .dec_sel(dec_sel), .gain_sel(gain_sel), .cic_in(cic_in), .cic_out(cic_out),
    .valid_out(valid_out), .overflow(overflow), .underflow(underflow), .dec_sel_out(dec_sel_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid_out) obs.push_back('{d: cic_out, o: overflow, u: underflow, c: cyc});

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic cfg(input logic [2:0] k, input logic [1:0] g);
    cfg_wr_en = 1'b1;
    dec_sel = k;
    gain_sel = g;
    step();
    cfg_wr_en = 1'b0;
    obs.delete();
    xs.delete();
  endtask

  task automatic feed(input logic [15:0] x);
    valid_in = 1'b1;
    cic_in = x;
    xs.push_back(int'($signed(x)));
    step();
    valid_in = 1'b0;
  endtask

  function automatic longint model(input int m, input int k, input int g, output logic o, output logic u);
    int     r = 1 << k;
    int     n = (m + 1) * r - 1;
    int     s = NS * k;
    longint h[];
    longint t[];
    longint y = 0;
    h = new[1];
    h[0] = 1;
    repeat (NS) begin
      t = new[h.size() + r - 1];
      foreach (t[i]) t[i] = 0;
      foreach (h[i]) for (int j = 0; j < r; j++) t[i+j] += h[i];
      h = t;
    end
    for (int i = 0; i < h.size(); i++) if (n - i >= 0) y += h[i] * longint'(xs[n-i]);
    if (s > 0) y = (y + (longint'(1) <<< (s - 1))) >>> s;
    y = y <<< g;
    o = y > 32767;
    u = y < -32768;
    return o ? 32767 : u ? -32768 : y;
  endfunction

  task automatic run_model(input string name, input int k, input int g, input int n, input int pat, input int tol);
    longint e, a;
    logic   o, u;
    cfg(3'(k), 2'(g));
    for (int i = 0; i < n; i++) feed(pat == 0 ? ((i % 2 == 1) ? 16'h8000 : 16'h7FFF) : 16'($urandom));
    idle(4);
    check({name, " count"}, obs.size(), n >> k);
    for (int m = NS; m < obs.size(); m++) begin
      e = model(m, k, g, o, u);
      a = longint'($signed(obs[m].d));
      tests++;
      if (a - e > tol || e - a > tol || obs[m].o != o || obs[m].u != u) begin
        fails++;
        $display("FAIL %s out%0d: got %0d o%0b u%0b, expected %0d o%0b u%0b", name, m, a, obs[m].o, obs[m].u, e, o, u);
      end
    end
  endtask

  initial begin
    vt[0]  = '{16'h4000, 3'd2, 2'd0, 16'h4000, 1'b0, 1'b0, 3'd2};
    vt[1]  = '{16'h3000, 3'd3, 2'd1, 16'h6000, 1'b0, 1'b0, 3'd3};
    vt[2]  = '{16'h3000, 3'd3, 2'd2, 16'h7FFF, 1'b1, 1'b0, 3'd3};
    vt[3]  = '{16'hD000, 3'd3, 2'd2, 16'h8000, 1'b0, 1'b1, 3'd3};
    vt[4]  = '{16'h1234, 3'd0, 2'd0, 16'h1234, 1'b0, 1'b0, 3'd0};
    vt[5]  = '{16'h1234, 3'd0, 2'd3, 16'h7FFF, 1'b1, 1'b0, 3'd0};
    vt[6]  = '{16'hF000, 3'd1, 2'd3, 16'h8000, 1'b0, 1'b0, 3'd1};
    vt[7]  = '{16'h0FFF, 3'd1, 2'd3, 16'h7FF8, 1'b0, 1'b0, 3'd1};
    vt[8]  = '{16'h0001, 3'd7, 2'd0, 16'h0001, 1'b0, 1'b0, 3'd4};
    vt[9]  = '{16'hFFFF, 3'd2, 2'd0, 16'hFFFF, 1'b0, 1'b0, 3'd2};
    vt[10] = '{16'h8000, 3'd4, 2'd0, 16'h8000, 1'b0, 1'b0, 3'd4};
    vt[11] = '{16'h7FFF, 3'd4, 2'd3, 16'h7FFF, 1'b1, 1'b0, 3'd4};
    rst = 1'b1; valid_in = 1'b1; bypass = 1'b0; cfg_wr_en = 1'b0;
    dec_sel = 3'd3; gain_sel = 2'd2; cic_in = 16'h5555;
    repeat (3) begin
      step();
      check("reset valid_out", valid_out, 0);
      check("reset cic_out", cic_out, 0);
      check("reset dec_sel_out", dec_sel_out, 0);
      check("reset flags", {overflow, underflow}, 0);
    end
    rst = 1'b0;
    idle(2);
    foreach (vt[i]) begin
      cfg(vt[i].ds, vt[i].gs);
      check($sformatf("vec%0d dec_sel_out", i), dec_sel_out, vt[i].k);
      for (int j = 0; j < ((NS + 3) << vt[i].k); j++) feed(vt[i].x);
      idle(4);
      check($sformatf("vec%0d count", i), obs.size(), NS + 3);
      if (obs.size() > 0) begin
        check($sformatf("vec%0d data", i), obs[obs.size()-1].d, vt[i].y);
        check($sformatf("vec%0d overflow", i), obs[obs.size()-1].o, vt[i].o);
        check($sformatf("vec%0d underflow", i), obs[obs.size()-1].u, vt[i].u);
      end
    end
    cfg(3'd2, 2'd0);
    for (int i = 0; i < 400; i++) feed(16'h4000);
    idle(4);
    check("dc400 count", obs.size(), 100);
    for (int i = 1; i < obs.size(); i++) begin
      check($sformatf("dc400 spacing%0d", i), obs[i].c - obs[i-1].c, 4);
      if (i >= NS) check($sformatf("dc400 data%0d", i), obs[i].d, 16'h4000);
    end
    run_model("fullscale", 4, 0, 32000, 0, 1);
    run_model("rand_k1", 1, 0, 400, 1, 0);
    run_model("rand_k3_g1", 3, 1, 800, 1, 0);
    cfg(3'd0, 2'd0);
    bypass = 1'b1;
    for (int i = 0; i < 256; i++) begin
      valid_in = (i % 3 == 0);
      cic_in = 16'(i * 257);
      step();
      check("bypass valid_out", valid_out, valid_in);
      if (valid_in) check("bypass data", cic_out, cic_in);
      check("bypass flags", {overflow, underflow}, 0);
    end
    valid_in = 1'b0;
    bypass = 1'b0;
    cfg(3'd2, 2'd0);
    repeat (4) feed(16'h4000);
    valid_in = 1'b1; cfg_wr_en = 1'b1; dec_sel = 3'd1; cic_in = 16'h4000;
    step();
    cfg_wr_en = 1'b0; valid_in = 1'b0;
    check("flush valid_out c0", valid_out, 0);
    check("flush dec_sel_out", dec_sel_out, 1);
    step();
    check("flush valid_out c1", valid_out, 0);
    step();
    check("flush valid_out c2", valid_out, 0);
    feed(16'h4000);
    check("k1 after 1st input", valid_out, 0);
    feed(16'h4000);
    check("k1 after 2nd input", valid_out, 0);
    step();
    check("k1 latency 1", valid_out, 0);
    step();
    check("k1 latency 2", valid_out, 1);
    step();
    check("k1 pulse", valid_out, 0);
    cfg(3'd7, 2'd0);
    check("clamp dec_sel_out", dec_sel_out, 4);
    cfg(3'd0, 2'd1);
    feed(16'h1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst valid_out 0", valid_out, 0);
    check("midrst cic_out", cic_out, 0);
    check("midrst dec_sel_out", dec_sel_out, 0);
    step();
    check("midrst valid_out 1", valid_out, 0);
    step();
    check("midrst valid_out 2", valid_out, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
